// File: rtl/calc_keypad_ctrl.sv
// Four-function keypad calculator: cursor-driven 4x4 keypad, 32-char input buffer,
// left-to-right unsigned evaluation scanning one buffered character per cycle.
module calc_keypad_ctrl #(
    parameter int MAX_LEN = 32
) (
    input  logic                   clk_in,
    input  logic                   sys_rst_n,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_sel,
    output logic [3:0]             cursor_x,
    output logic [3:0]             cursor_y,
    output logic [8*MAX_LEN-1:0]   disp_str_flat,
    output logic [31:0]            result,
    output logic                   calc_done
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {ST_INPUT, ST_EVAL, ST_DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         char_buf [MAX_LEN];
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   idx;
    logic [31:0]        acc;
    logic [31:0]        operand;
    logic [7:0]         op;

    function automatic logic [7:0] key_char(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_char = 8'h31;  4'h1: key_char = 8'h32;
            4'h2: key_char = 8'h33;  4'h3: key_char = 8'h2B;
            4'h4: key_char = 8'h34;  4'h5: key_char = 8'h35;
            4'h6: key_char = 8'h36;  4'h7: key_char = 8'h2D;
            4'h8: key_char = 8'h37;  4'h9: key_char = 8'h38;
            4'hA: key_char = 8'h39;  4'hB: key_char = 8'h2A;
            4'hC: key_char = 8'h43;  4'hD: key_char = 8'h30;
            4'hE: key_char = 8'h3D;  default: key_char = 8'h42;
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] ch);
        is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    endfunction

    function automatic logic [31:0] apply_op(input logic [31:0] a, input logic [7:0] o,
                                             input logic [31:0] b);
        case (o)
            8'h2D:   apply_op = a - b;
            8'h2A:   apply_op = a * b;
            default: apply_op = a + b;
        endcase
    endfunction

    // sel decodes the cursor as registered before this edge
    logic [7:0] sel_char;
    logic       sel_digop, sel_clear, sel_back, sel_eq;
    logic [7:0] scan_char;

    assign sel_char  = key_char(cursor_y[1:0], cursor_x[1:0]);
    assign sel_digop = is_digit(sel_char) || sel_char == 8'h2B || sel_char == 8'h2D
                       || sel_char == 8'h2A;
    assign sel_clear = sel_char == 8'h43;
    assign sel_back  = sel_char == 8'h42;
    assign sel_eq    = sel_char == 8'h3D;
    assign scan_char = char_buf[idx[IDX_W-1:0]];

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cursor_x <= 4'd0;
            cursor_y <= 4'd0;
        end else begin
            if (btn_up)         cursor_y <= {2'b00, cursor_y[1:0] - 2'd1};
            else if (btn_down)  cursor_y <= {2'b00, cursor_y[1:0] + 2'd1};
            if (btn_left)       cursor_x <= {2'b00, cursor_x[1:0] - 2'd1};
            else if (btn_right) cursor_x <= {2'b00, cursor_x[1:0] + 2'd1};
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_INPUT;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INPUT: if (btn_sel && sel_eq) state_nxt = ST_EVAL;
            ST_EVAL:  if (idx == len) state_nxt = ST_DONE;
            ST_DONE:  if (btn_sel && !sel_eq) state_nxt = ST_INPUT;
            default:  state_nxt = ST_INPUT;
        endcase
    end

    logic act_clear, act_write, act_back, act_start, act_step, act_finish, act_cdone_clr;

    always_comb begin
        act_clear     = 1'b0;
        act_write     = 1'b0;
        act_back      = 1'b0;
        act_start     = 1'b0;
        act_step      = 1'b0;
        act_finish    = 1'b0;
        act_cdone_clr = 1'b0;
        case (state)
            ST_INPUT: if (btn_sel) begin
                act_write = sel_digop && (len < LEN_MAX);
                act_back  = sel_back && (len != '0);
                act_clear = sel_clear;
                act_start = sel_eq;
            end
            ST_EVAL: begin
                act_finish = (idx == len);
                act_step   = (idx != len);
            end
            ST_DONE: if (btn_sel) begin
                act_clear     = sel_digop || sel_clear;
                act_write     = sel_digop;
                act_cdone_clr = sel_back;
            end
            default: ;
        endcase
    end

    // a clear and a write on the same edge restart the buffer at index 0
    logic [LEN_W-1:0] wr_idx;
    assign wr_idx = act_clear ? '0 : len;

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) char_buf[i] <= 8'h20;
            len       <= '0;
            idx       <= '0;
            acc       <= '0;
            operand   <= '0;
            op        <= 8'h2B;
            result    <= '0;
            calc_done <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (act_write && LEN_W'(i) == wr_idx)               char_buf[i] <= sel_char;
                else if (act_clear)                                 char_buf[i] <= 8'h20;
                else if (act_back && LEN_W'(i) == len - LEN_W'(1))  char_buf[i] <= 8'h20;
            end
            if (act_write)     len <= wr_idx + LEN_W'(1);
            else if (act_clear) len <= '0;
            else if (act_back)  len <= len - LEN_W'(1);

            if (act_start) begin
                idx     <= '0;
                acc     <= '0;
                operand <= '0;
                op      <= 8'h2B;
            end else if (act_step) begin
                idx <= idx + LEN_W'(1);
                if (is_digit(scan_char)) begin
                    operand <= operand * 32'd10 + {28'd0, scan_char[3:0]};
                end else begin
                    acc     <= apply_op(acc, op, operand);
                    op      <= scan_char;
                    operand <= '0;
                end
            end

            if (act_finish) begin
                result    <= apply_op(acc, op, operand);
                calc_done <= 1'b1;
            end else if (act_clear || act_write || act_cdone_clr) begin
                calc_done <= 1'b0;
            end
        end
    end

    always_comb begin
        disp_str_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) disp_str_flat[i*8 +: 8] = char_buf[i];
    end

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
// Directed bench for calc_keypad_ctrl: cursor vector table plus key-entry sequences.
module tb_calc_keypad_ctrl;

    logic         clk_in = 1'b0;
    logic         sys_rst_n;
    logic         btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [3:0]   cursor_x, cursor_y;
    logic [255:0] disp_str_flat;
    logic [31:0]  result;
    logic         calc_done;

    int n_tests = 0;
    int n_fail  = 0;
    int my_x    = 0;
    int my_y    = 0;
    string keymap = "123+456-789*C0=B";

    calc_keypad_ctrl #(.MAX_LEN(32)) dut (
        .clk_in(clk_in), .sys_rst_n(sys_rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .disp_str_flat(disp_str_flat), .result(result), .calc_done(calc_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       up, down, left, right;
        logic [3:0] ex, ey;
    } cur_vec_t;

    cur_vec_t vecs [9];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] build_disp(input string s);
        logic [255:0] r;
        r = {32{8'h20}};
        for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                         input logic s);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        @(posedge clk_in);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    endtask

    task automatic press(input byte ch);
        int row, col;
        row = 0; col = 0;
        for (int i = 0; i < 16; i++) if (keymap[i] == ch) begin row = i / 4; col = i % 4; end
        while (my_y != row) begin pulse(0, 1, 0, 0, 0); my_y = (my_y + 1) % 4; end
        while (my_x != col) begin pulse(0, 0, 0, 1, 0); my_x = (my_x + 1) % 4; end
        pulse(0, 0, 0, 0, 1);
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i]);
    endtask

    // "=" then step through the evaluation, checking done latency and value
    task automatic eval_check(input string name, input int len, input logic [31:0] exp,
                              input logic sel_mid);
        press(8'h3D);
        for (int k = 1; k <= len + 1; k++) begin
            if (k == 1 && sel_mid) btn_sel = 1;
            @(posedge clk_in);
            #1;
            btn_sel = 0;
            if (k == len) check({name, "_done_early"}, {255'd0, calc_done}, 256'd0);
            if (k == len + 1) begin
                check({name, "_done"}, {255'd0, calc_done}, 256'd1);
                check({name, "_result"}, {224'd0, result}, {224'd0, exp});
            end
        end
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 4'd0, 4'd3}; // up from (0,0)
        vecs[1] = '{0, 0, 1, 0, 4'd3, 4'd3}; // left
        vecs[2] = '{0, 0, 1, 1, 4'd2, 4'd3}; // left+right: left wins
        vecs[3] = '{1, 1, 0, 0, 4'd2, 4'd2}; // up+down: up wins
        vecs[4] = '{0, 0, 0, 1, 4'd3, 4'd2};
        vecs[5] = '{0, 0, 0, 1, 4'd0, 4'd2}; // x wraps 3->0
        vecs[6] = '{0, 1, 0, 0, 4'd0, 4'd3};
        vecs[7] = '{0, 1, 0, 0, 4'd0, 4'd0}; // y wraps 3->0
        vecs[8] = '{0, 0, 0, 0, 4'd0, 4'd0};

        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
        sys_rst_n = 0;
        #12;
        check("rst_cursor", {248'd0, cursor_y, cursor_x}, 256'd0);
        check("rst_disp", disp_str_flat, build_disp(""));
        check("rst_result", {224'd0, result}, 256'd0);
        check("rst_done", {255'd0, calc_done}, 256'd0);
        sys_rst_n = 1;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right, 0);
            check($sformatf("cursor_vec%0d", i), {248'd0, cursor_y, cursor_x},
                  {248'd0, vecs[i].ey, vecs[i].ex});
        end
        my_x = 0; my_y = 0;

        type_str("12+3");
        check("disp_12p3", disp_str_flat, build_disp("12+3"));
        eval_check("eval_12p3", 4, 32'd15, 1'b0);
        check("disp_after_eval", disp_str_flat, build_disp("12+3"));

        press(8'h39);
        check("done_9_calc_done", {255'd0, calc_done}, 256'd0);
        check("done_9_disp", disp_str_flat, build_disp("9"));
        check("done_9_result", {224'd0, result}, 256'd15);

        press(8'h43);
        type_str("7*6-50");
        eval_check("eval_neg8", 6, 32'hFFFF_FFF8, 1'b0);
        press(8'h43);
        type_str("7*6-50B");
        check("disp_back", disp_str_flat, build_disp("7*6-5"));
        eval_check("eval_37", 5, 32'd37, 1'b0);

        press(8'h42);
        check("done_back_calc_done", {255'd0, calc_done}, 256'd0);
        check("done_back_disp", disp_str_flat, build_disp("7*6-5"));
        press(8'h43);
        type_str("12+3");
        eval_check("eval_sel_mid", 4, 32'd15, 1'b1);
        check("disp_sel_mid", disp_str_flat, build_disp("12+3"));

        press(8'h43);
        type_str("-5");
        eval_check("eval_lead_minus", 2, 32'hFFFF_FFFB, 1'b0);

        press(8'h43);
        for (int i = 0; i < 33; i++) press(byte'(8'h30 + i % 10));
        check("disp_overflow", disp_str_flat,
              build_disp("01234567890123456789012345678901"));
        press(8'h43);
        check("disp_clear", disp_str_flat, build_disp(""));
        press(8'h42);
        check("back_at_len0", disp_str_flat, build_disp(""));

        type_str("12+3");
        press(8'h3D);
        repeat (2) @(posedge clk_in);
        #2;
        sys_rst_n = 0;
        #1;
        check("midrst_cursor", {248'd0, cursor_y, cursor_x}, 256'd0);
        check("midrst_disp", disp_str_flat, build_disp(""));
        check("midrst_result", {224'd0, result}, 256'd0);
        check("midrst_done", {255'd0, calc_done}, 256'd0);
        #2;
        sys_rst_n = 1;
        my_x = 0; my_y = 0;
        @(posedge clk_in);
        #1;
        check("post_rst_done", {255'd0, calc_done}, 256'd0);

        type_str("5");
        eval_check("eval_5", 1, 32'd5, 1'b0);
        press(8'h43);
        check("clear_keeps_result", {224'd0, result}, 256'd5);
        eval_check("eval_empty", 0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
